// File: rtl/tcp_tx_app_update_arb.sv
// Two-requester round-robin arbiter for TCP TX tail-pointer updates.
// Each accepted update writes the tail memory first, then marks the flow schedulable.
module tcp_tx_app_update_arb #(
  parameter int          FLOWID_W    = 8,
  parameter int          PTR_W       = 17,
  parameter logic [15:0] UPD_CNT_RST = 16'd0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_val,
  input  logic [FLOWID_W-1:0] req0_flowid,
  input  logic [PTR_W-1:0]    req0_tail,
  output logic                req0_rdy,
  input  logic                req1_val,
  input  logic [FLOWID_W-1:0] req1_flowid,
  input  logic [PTR_W-1:0]    req1_tail,
  output logic                req1_rdy,
  output logic                tail_wr_val,
  output logic [FLOWID_W-1:0] tail_wr_addr,
  output logic [PTR_W-1:0]    tail_wr_data,
  input  logic                tail_wr_rdy,
  output logic                sched_val,
  output logic [FLOWID_W-1:0] sched_flowid,
  input  logic                sched_rdy,
  output logic                busy,
  output logic [15:0]         upd_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TAIL_WR = 2'd1,
    SCHED   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic [FLOWID_W-1:0] flow_q, flow_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                idle;
  logic                gnt0, gnt1;

  // last_q = 1 means requester 1 won most recently
  assign idle = (state_q == IDLE);
  assign gnt0 = req0_val & (~req1_val | last_q);
  assign gnt1 = req1_val & (~req0_val | ~last_q);

  assign req0_rdy     = idle & gnt0;
  assign req1_rdy     = idle & gnt1;
  assign tail_wr_val  = (state_q == TAIL_WR);
  assign sched_val    = (state_q == SCHED);
  assign busy         = ~idle;
  assign tail_wr_addr = flow_q;
  assign tail_wr_data = tail_q;
  assign sched_flowid = flow_q;
  assign upd_cnt      = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      flow_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= UPD_CNT_RST;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      flow_q  <= flow_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    flow_d  = flow_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          gnt0: begin
            flow_d  = req0_flowid;
            tail_d  = req0_tail;
            last_d  = 1'b0;
            state_d = TAIL_WR;
          end
          gnt1: begin
            flow_d  = req1_flowid;
            tail_d  = req1_tail;
            last_d  = 1'b1;
            state_d = TAIL_WR;
          end
          default: ;
        endcase
      end
      TAIL_WR: begin
        if (tail_wr_rdy) state_d = SCHED;
      end
      SCHED: begin
        if (sched_rdy) begin
          state_d = IDLE;
          cnt_d   = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tcp_tx_app_update_arb.sv
// Directed bench for tcp_tx_app_update_arb with a per-cycle
// transaction-level reference model and handshake ordering monitor.
module tb_tcp_tx_app_update_arb;

  localparam int FW = 8;
  localparam int PW = 17;

  logic          clk, rst_n;
  logic          req0_val, req1_val;
  logic [FW-1:0] req0_flowid, req1_flowid;
  logic [PW-1:0] req0_tail, req1_tail;
  logic          req0_rdy, req1_rdy;
  logic          tail_wr_val, tail_wr_rdy;
  logic [FW-1:0] tail_wr_addr;
  logic [PW-1:0] tail_wr_data;
  logic          sched_val, sched_rdy;
  logic [FW-1:0] sched_flowid;
  logic          busy;
  logic [15:0]   upd_cnt;

  logic          w_req0_val;
  logic          w_req0_rdy, w_req1_rdy;
  logic          w_tail_wr_val, w_sched_val, w_busy;
  logic [FW-1:0] w_tail_wr_addr, w_sched_flowid;
  logic [PW-1:0] w_tail_wr_data;
  logic [15:0]   w_upd_cnt;

  int n_cmp = 0;
  int n_err = 0;

  tcp_tx_app_update_arb #(.FLOWID_W(FW), .PTR_W(PW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_val(req0_val), .req0_flowid(req0_flowid),
    .req0_tail(req0_tail), .req0_rdy(req0_rdy),
    .req1_val(req1_val), .req1_flowid(req1_flowid),
    .req1_tail(req1_tail), .req1_rdy(req1_rdy),
    .tail_wr_val(tail_wr_val), .tail_wr_addr(tail_wr_addr),
    .tail_wr_data(tail_wr_data), .tail_wr_rdy(tail_wr_rdy),
    .sched_val(sched_val), .sched_flowid(sched_flowid),
    .sched_rdy(sched_rdy), .busy(busy), .upd_cnt(upd_cnt)
  );

  // Counter starts near the top so the wrap is reachable in a few updates
  tcp_tx_app_update_arb #(
    .FLOWID_W(FW), .PTR_W(PW), .UPD_CNT_RST(16'hFFFD)
  ) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .req0_val(w_req0_val), .req0_flowid(8'd1),
    .req0_tail(17'h00042), .req0_rdy(w_req0_rdy),
    .req1_val(1'b0), .req1_flowid(8'd0),
    .req1_tail(17'h0), .req1_rdy(w_req1_rdy),
    .tail_wr_val(w_tail_wr_val), .tail_wr_addr(w_tail_wr_addr),
    .tail_wr_data(w_tail_wr_data), .tail_wr_rdy(1'b1),
    .sched_val(w_sched_val), .sched_flowid(w_sched_flowid),
    .sched_rdy(1'b1), .busy(w_busy), .upd_cnt(w_upd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: one in-flight update, written then scheduled
  bit            m_busy, m_written, m_last;
  logic [FW-1:0] m_flow;
  logic [PW-1:0] m_tail;
  logic [15:0]   m_cnt;
  bit            e0, e1;
  bit            wr_pend;
  logic [FW-1:0] last_wr_flow;
  int            wr_hs = 0;
  int            sc_hs = 0;
  int            grant_log[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_written = 0; m_last = 1;
      m_cnt = '0; wr_pend = 0;
    end else begin
      e0 = !m_busy && req0_val && (!req1_val || m_last);
      e1 = !m_busy && req1_val && (!req0_val || !m_last);
      chk("req0_rdy", req0_rdy, e0);
      chk("req1_rdy", req1_rdy, e1);
      chk("tail_wr_val", tail_wr_val, m_busy && !m_written);
      chk("sched_val", sched_val, m_busy && m_written);
      chk("busy", busy, m_busy);
      chk("upd_cnt", upd_cnt, m_cnt);
      if (m_busy && !m_written) begin
        chk("tail_wr_addr", tail_wr_addr, m_flow);
        chk("tail_wr_data", tail_wr_data, m_tail);
      end
      if (m_busy && m_written)
        chk("sched_flowid", sched_flowid, m_flow);
      if (tail_wr_val && tail_wr_rdy) begin
        wr_hs++;
        wr_pend = 1;
        last_wr_flow = tail_wr_addr;
      end
      if (sched_val && sched_rdy) begin
        sc_hs++;
        chk("order_wr_first", wr_pend, 1);
        chk("order_flow", sched_flowid, last_wr_flow);
        wr_pend = 0;
      end
      if (req0_val && req0_rdy) grant_log.push_back(0);
      if (req1_val && req1_rdy) grant_log.push_back(1);
      if (m_busy && !m_written) begin
        if (tail_wr_rdy) m_written = 1;
      end else if (m_busy) begin
        if (sched_rdy) begin
          m_busy = 0;
          m_cnt = m_cnt + 16'd1;
        end
      end else if (e0) begin
        m_busy = 1; m_written = 0; m_last = 0;
        m_flow = req0_flowid; m_tail = req0_tail;
      end else if (e1) begin
        m_busy = 1; m_written = 0; m_last = 1;
        m_flow = req1_flowid; m_tail = req1_tail;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0_val = 0; req1_val = 0; w_req0_val = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  int w0, s0;
  bit a0, a1;

  initial begin
    rst_n = 0;
    req0_val = 0; req1_val = 0; w_req0_val = 0;
    req0_flowid = '0; req1_flowid = '0;
    req0_tail = '0; req1_tail = '0;
    tail_wr_rdy = 1; sched_rdy = 1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_tail_wr_val", tail_wr_val, 0);
    chk("rst_sched_val", sched_val, 0);
    chk("rst_upd_cnt", upd_cnt, 0);
    chk("rst_tail_wr_data", tail_wr_data, 0);
    do_reset();

    // Single request
    req0_val = 1; req0_flowid = 8'd5; req0_tail = 17'h00123;
    #1;
    chk("t1_req0_rdy", req0_rdy, 1);
    tick();
    req0_val = 0;
    chk("t1_wr_val", tail_wr_val, 1);
    chk("t1_wr_addr", tail_wr_addr, 5);
    chk("t1_wr_data", tail_wr_data, 17'h00123);
    chk("t1_no_sched", sched_val, 0);
    tick();
    chk("t1_sched_val", sched_val, 1);
    chk("t1_sched_flow", sched_flowid, 5);
    chk("t1_no_wr", tail_wr_val, 0);
    tick();
    chk("t1_cnt", upd_cnt, 1);
    chk("t1_idle", busy, 0);

    // Contention from a fresh reset
    do_reset();
    grant_log.delete();
    req0_val = 1; req0_flowid = 8'd1; req0_tail = 17'h11;
    req1_val = 1; req1_flowid = 8'd2; req1_tail = 17'h22;
    repeat (12) tick();
    req0_val = 0; req1_val = 0;
    chk("t2_cnt", upd_cnt, 4);
    chk("t2_ngrants", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      chk("t2_grant_order", grant_log[i], i % 2);

    // Backpressure on both sinks
    req1_val = 1; req1_flowid = 8'd9; req1_tail = 17'h1ABCD;
    tail_wr_rdy = 0; sched_rdy = 1;
    #1;
    chk("t3_req1_rdy", req1_rdy, 1);
    w0 = wr_hs; s0 = sc_hs;
    tick();
    req0_val = 1; req0_flowid = 8'd3; req0_tail = 17'h333;
    repeat (5) begin
      chk("t3_wr_hold", tail_wr_val, 1);
      chk("t3_wr_data", tail_wr_data, 17'h1ABCD);
      chk("t3_rdy0_low", req0_rdy, 0);
      chk("t3_rdy1_low", req1_rdy, 0);
      tick();
    end
    tail_wr_rdy = 1; sched_rdy = 0;
    tick();
    tail_wr_rdy = 0;
    repeat (3) begin
      chk("t3_sched_hold", sched_val, 1);
      chk("t3_sched_flow", sched_flowid, 9);
      chk("t3_rdy0_low_s", req0_rdy, 0);
      tick();
    end
    sched_rdy = 1;
    tick();
    chk("t3_one_wr", wr_hs - w0, 1);
    chk("t3_one_sched", sc_hs - s0, 1);
    chk("t3_rr_req0", req0_rdy, 1);
    tail_wr_rdy = 1;
    tick();
    req0_val = 0;
    repeat (2) tick();
    chk("t3_same_flow_again", req1_rdy, 1);
    tick();
    req1_val = 0;
    repeat (2) tick();
    chk("t3_cnt", upd_cnt, 7);

    // Reset while the tail write is stalled
    req0_val = 1; req0_flowid = 8'd7; req0_tail = 17'h77;
    tail_wr_rdy = 0;
    tick();
    req0_val = 0;
    chk("t4_in_wr", tail_wr_val, 1);
    #1 rst_n = 0;
    #1;
    chk("t4_async_wr_drop", tail_wr_val, 0);
    chk("t4_async_busy", busy, 0);
    chk("t4_async_cnt", upd_cnt, 0);
    s0 = sc_hs;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1;
    tail_wr_rdy = 1; sched_rdy = 1;
    req1_val = 1; req1_flowid = 8'd4; req1_tail = 17'h44;
    #1;
    chk("t4_rdy_first_cycle", req1_rdy, 1);
    tick();
    req1_val = 0;
    repeat (4) tick();
    chk("t4_one_sched", sc_hs - s0, 1);
    chk("t4_cnt", upd_cnt, 1);

    // Random traffic and stalls
    for (int i = 0; i < 400; i++) begin
      a0 = req0_val && req0_rdy;
      a1 = req1_val && req1_rdy;
      tick();
      if (!req0_val || a0) begin
        req0_val = 1'($urandom_range(0, 1));
        req0_flowid = 8'($urandom_range(0, 15));
        req0_tail = 17'($urandom);
      end
      if (!req1_val || a1) begin
        req1_val = 1'($urandom_range(0, 1));
        req1_flowid = 8'($urandom_range(0, 15));
        req1_tail = 17'($urandom);
      end
      tail_wr_rdy = ($urandom_range(0, 3) != 0);
      sched_rdy = ($urandom_range(0, 3) != 0);
    end
    a0 = req0_val && req0_rdy;
    a1 = req1_val && req1_rdy;
    tick();
    if (a0) req0_val = 0;
    if (a1) req1_val = 0;
    tail_wr_rdy = 1; sched_rdy = 1;
    for (int i = 0; i < 12; i++) begin
      a0 = req0_val && req0_rdy;
      a1 = req1_val && req1_rdy;
      tick();
      if (a0) req0_val = 0;
      if (a1) req1_val = 0;
    end
    chk("t5_drained", busy, 0);
    chk("t5_hs_balance", wr_hs, sc_hs);

    // Counter wrap
    do_reset();
    chk("t6_preload", w_upd_cnt, 16'hFFFD);
    w_req0_val = 1;
    repeat (3) tick();
    chk("t6_cnt_fffe", w_upd_cnt, 16'hFFFE);
    repeat (3) tick();
    chk("t6_cnt_ffff", w_upd_cnt, 16'hFFFF);
    repeat (3) tick();
    chk("t6_cnt_wrap", w_upd_cnt, 16'h0000);
    w_req0_val = 0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tcp_tx_app_update_arb.md
TCP_TX_APP_UPDATE_ARB -- requirements
Module: tcp_tx_app_update_arb

Interface
REQ-001 Parameter FLOWID_W, default 8, flow ID width.
REQ-002 Parameter PTR_W, default 17, tail pointer width including the wrap bit.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 req0_val  input  1  requester 0 (NoC message interface) update valid.
REQ-006 req0_flowid  input  FLOWID_W  requester 0 flow ID.
REQ-007 req0_tail  input  PTR_W  requester 0 new tail pointer.
REQ-008 req0_rdy  output  1  requester 0 accept.
REQ-009 req1_val, req1_flowid, req1_tail, req1_rdy  same directions and widths as requester 0; requester 1 is the local/loopback source.
REQ-010 tail_wr_val  output  1  tail pointer memory write valid.
REQ-011 tail_wr_addr  output  FLOWID_W  write address (flow ID).
REQ-012 tail_wr_data  output  PTR_W  write data (tail pointer).
REQ-013 tail_wr_rdy  input  1  tail pointer memory accepts the write.
REQ-014 sched_val  output  1  scheduler "flow has data" update valid.
REQ-015 sched_flowid  output  FLOWID_W  flow to mark schedulable.
REQ-016 sched_rdy  input  1  scheduler accepts the update.
REQ-017 busy  output  1  high whenever the FSM is not in IDLE.
REQ-018 upd_cnt  output  16  count of completed updates; wraps at 65535 -> 0.

Function
REQ-019 The FSM SHALL have three states: IDLE, TAIL_WR, SCHED.
REQ-020 In IDLE, reqN_rdy SHALL be asserted only for the requester selected by the arbiter; in all other states both rdy outputs SHALL be 0.
REQ-021 Arbitration SHALL be round-robin: when only one requester is valid, it wins; when both are valid, the one not granted last wins.
REQ-022 The last-grant register SHALL reset to 1, so requester 0 wins the first contested cycle.
REQ-023 A transfer (val & rdy in IDLE) SHALL latch flowid and tail into internal registers, update last-grant, and move to TAIL_WR on the next edge.
REQ-024 In TAIL_WR, tail_wr_val SHALL be 1 with the latched addr and data held stable; on tail_wr_rdy the FSM SHALL move to SCHED.
REQ-025 In SCHED, sched_val SHALL be 1 with the latched flowid held stable; on sched_rdy the FSM SHALL return to IDLE and upd_cnt SHALL increment by 1.
REQ-026 The tail write SHALL always complete before the scheduler update for the same request, so the scheduler never observes a stale tail.
REQ-027 Minimum occupancy SHALL be 3 cycles per update: accept, write, schedule.
REQ-028 A new request SHALL be accepted on the first IDLE cycle after SCHED completes.
REQ-029 tail_wr_val and sched_val SHALL never be asserted in the same cycle.
REQ-030 The block SHALL have no combinational path from tail_wr_rdy or sched_rdy to any reqN_rdy output.
REQ-031 reqN_rdy SHALL depend only on FSM state, last-grant, and the two val inputs.
REQ-032 Requesters SHALL hold val, flowid, and tail stable until accepted; the block does not check this.
REQ-033 Stalls SHALL be unbounded: the block holds its current state and outputs indefinitely while the relevant rdy is low.
REQ-034 Consecutive requests for the same flow ID SHALL be processed as separate updates, with no coalescing.

Reset
REQ-035 On rst_n low, asynchronously: FSM = IDLE; last-grant = 1; upd_cnt = 0; latched flowid and tail = 0; all val outputs = 0; busy = 0.
REQ-036 A reset asserted mid-operation SHALL discard the in-flight update; no partial write or scheduler update is issued after rst_n deasserts.
REQ-037 After rst_n deasserts, reqN_rdy SHALL be combinationally valid in the first cycle.

Verification
REQ-038 Single request: req0 flowid=5, tail=0x00123 with both sinks ready -> req0_rdy in cycle 0; tail_wr addr=5, data=0x00123 in cycle 1; sched flowid=5 in cycle 2; upd_cnt=1.
REQ-039 Contention: req0 and req1 continuously valid (flows 1 and 2) -> grant order 0,1,0,1; upd_cnt=4 after 12 cycles.
REQ-040 Backpressure: tail_wr_rdy low for 5 cycles, then sched_rdy low for 3 cycles -> outputs held stable throughout; reqN_rdy=0 throughout; exactly one write and one scheduler update issued.
REQ-041 Reset in TAIL_WR: rst_n pulsed low -> tail_wr_val drops asynchronously; no sched_val follows; upd_cnt=0.
REQ-042 Counter wrap: preload via 65536 updates -> upd_cnt reads 0.
REQ-043 Ordering: with random stalls, a checker asserts that each sched_val handshake is preceded by a tail_wr handshake with the same flowid, and that the two never overlap.
